// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, bus mode encoding and responder state.
package spi_pkg;

  localparam int unsigned SPI_BYTE_WIDTH = 8;
  localparam int unsigned SPI_CNT_WIDTH  = $clog2(SPI_BYTE_WIDTH);

  // Clock polarity: idle level of sclk
  localparam bit SPI_CPOL_IDLE_LOW  = 1'b0;
  localparam bit SPI_CPOL_IDLE_HIGH = 1'b1;

  // Clock phase: which sclk edge samples data
  localparam bit SPI_CPHA_SAMPLE_LEAD  = 1'b0;
  localparam bit SPI_CPHA_SAMPLE_TRAIL = 1'b1;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  function automatic spi_mode_e spi_mode(input bit cpol, input bit cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_peripheral_sync.sv
// Two-flop synchronizer with a trailing flop for rise/fall detection.
module spi_peripheral_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resynchronize the pin and keep the previous synchronized value
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI responder: oversampled bus, full-duplex MSB-first bytes, one-deep tx buffer.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter bit                        CPOL       = SPI_CPOL_IDLE_LOW,
  parameter bit                        CPHA       = SPI_CPHA_SAMPLE_LEAD,
  parameter logic [SPI_BYTE_WIDTH-1:0] DEFAULT_TX = 8'h00
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sclk,
  input  logic                      cs,
  input  logic                      pico,
  output logic                      poci,
  output logic                      poci_oe,
  input  logic [SPI_BYTE_WIDTH-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [SPI_BYTE_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      tx_underrun,
  output logic                      busy
);

  localparam logic [SPI_CNT_WIDTH-1:0] LAST_BIT = SPI_CNT_WIDTH'(SPI_BYTE_WIDTH - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level_unused, cs_rise, cs_fall;
  logic pico_s, pico_rise_unused, pico_fall_unused;

  spi_peripheral_sync #(.RESET_VAL(CPOL)) u_sclk_sync (
    .clock (clock),
    .reset (reset),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_peripheral_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clock (clock),
    .reset (reset),
    .din   (cs),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_peripheral_sync #(.RESET_VAL(1'b0)) u_pico_sync (
    .clock (clock),
    .reset (reset),
    .din   (pico),
    .level (pico_s),
    .rise  (pico_rise_unused),
    .fall  (pico_fall_unused)
  );

  spi_state_e                  state, state_nxt;
  logic                        start, abort;
  logic [SPI_BYTE_WIDTH-1:0]   tx_shift;
  logic [SPI_BYTE_WIDTH-2:0]   rx_shift;
  logic [SPI_CNT_WIDTH-1:0]    bit_cnt;
  logic                        reload_pending;
  logic [SPI_BYTE_WIDTH-1:0]   tx_buf;
  logic                        buf_full;

  logic                        lead_edge, trail_edge;
  logic                        sample_ev, shift_ev;
  logic                        run, do_sample, do_shift, last_sample;
  logic                        need_load, shift_ok;
  logic [SPI_BYTE_WIDTH-1:0]   load_byte;
  logic                        load_empty;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= SPI_IDLE;
    else       state <= state_nxt;
  end

  // Next state: cs edges alone move between idle and active
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_nxt = SPI_ACTIVE;
          start     = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (cs_rise) begin
          state_nxt = SPI_IDLE;
          abort     = 1'b1;
        end
      end
      default: state_nxt = SPI_IDLE;
    endcase
  end

  // Edge roles and load selection; a cs edge masks any sclk edge in the same cycle
  always_comb begin
    lead_edge   = CPOL ? sclk_fall : sclk_rise;
    trail_edge  = CPOL ? sclk_rise : sclk_fall;
    sample_ev   = CPHA ? trail_edge : lead_edge;
    shift_ev    = CPHA ? lead_edge : trail_edge;
    run         = (state == SPI_ACTIVE) && !cs_rise;
    do_sample   = run && sample_ev;
    do_shift    = run && shift_ev;
    last_sample = do_sample && (bit_cnt == LAST_BIT);
    need_load   = start || (CPHA ? last_sample : (do_shift && reload_pending));
    shift_ok    = CPHA ? (bit_cnt != '0) : 1'b1;
    load_empty  = 1'b0;
    if (buf_full) begin
      load_byte = tx_buf;
    end else if (tx_valid) begin
      load_byte = tx_data;
    end else begin
      load_byte  = DEFAULT_TX;
      load_empty = 1'b1;
    end
  end

  // Holding buffer: freed by a load, filled by a handshake outside load cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else if (need_load && buf_full) begin
      buf_full <= 1'b0;
    end else if (tx_valid && !buf_full && !need_load) begin
      tx_buf   <= tx_data;
      buf_full <= 1'b1;
    end
  end

  // Shift datapath, bit counter and receive capture
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_shift       <= '0;
      rx_shift       <= '0;
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      tx_underrun    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (need_load) begin
        tx_shift    <= load_byte;
        tx_underrun <= load_empty;
      end else if (do_shift && shift_ok) begin
        tx_shift <= {tx_shift[SPI_BYTE_WIDTH-2:0], 1'b0};
      end else if (abort) begin
        tx_shift <= '0;
      end

      if (start || abort) begin
        bit_cnt        <= '0;
        reload_pending <= 1'b0;
        rx_shift       <= '0;
      end else begin
        if (do_sample) begin
          rx_shift <= {rx_shift[SPI_BYTE_WIDTH-3:0], pico_s};
          bit_cnt  <= bit_cnt + SPI_CNT_WIDTH'(1);
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= {rx_shift, pico_s};
            rx_valid <= 1'b1;
            if (!CPHA) reload_pending <= 1'b1;
          end
        end
        if (do_shift && !CPHA && reload_pending) reload_pending <= 1'b0;
      end
    end
  end

  assign busy     = (state == SPI_ACTIVE);
  assign poci_oe  = (state == SPI_ACTIVE);
  assign poci     = (state == SPI_ACTIVE) && tx_shift[SPI_BYTE_WIDTH-1];
  assign tx_ready = !buf_full;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench: mode 0 and mode 3 responders driven by a bit-banged controller.
module tb_spi_peripheral;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       sclk0 = 1'b0, cs0 = 1'b1, pico0 = 1'b0, txv0 = 1'b0;
  logic [7:0] txd0 = 8'h00;
  logic       poci0, oe0, rdy0, rxv0, und0, busy0;
  logic [7:0] rxd0;

  logic       sclk3 = 1'b1, cs3 = 1'b1, pico3 = 1'b0, txv3 = 1'b0;
  logic [7:0] txd3 = 8'h00;
  logic       poci3, oe3, rdy3, rxv3, und3, busy3;
  logic [7:0] rxd3;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt0 = 0, und_cnt0 = 0, rx_cnt3 = 0, und_cnt3 = 0;
  logic [7:0] rx_log3 [0:15];

  always #5 clock = ~clock;

  spi_peripheral #(.CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'h5A)) u0 (
    .clock(clock), .reset(reset), .sclk(sclk0), .cs(cs0), .pico(pico0),
    .poci(poci0), .poci_oe(oe0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(rdy0), .rx_data(rxd0), .rx_valid(rxv0),
    .tx_underrun(und0), .busy(busy0)
  );

  spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'h00)) u3 (
    .clock(clock), .reset(reset), .sclk(sclk3), .cs(cs3), .pico(pico3),
    .poci(poci3), .poci_oe(oe3), .tx_data(txd3), .tx_valid(txv3),
    .tx_ready(rdy3), .rx_data(rxd3), .rx_valid(rxv3),
    .tx_underrun(und3), .busy(busy3)
  );

  // Pulse monitors
  always @(negedge clock) begin
    if (rxv0 === 1'b1) rx_cnt0 <= rx_cnt0 + 1;
    if (und0 === 1'b1) und_cnt0 <= und_cnt0 + 1;
    if (rxv3 === 1'b1) begin
      rx_log3[rx_cnt3 % 16] <= rxd3;
      rx_cnt3 <= rx_cnt3 + 1;
    end
    if (und3 === 1'b1) und_cnt3 <= und_cnt3 + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push0(input logic [7:0] d);
    int waited = 0;
    while (rdy0 !== 1'b1 && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    vectors++;
    if (rdy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL push0_ready got %b expected 1", rdy0);
    end else begin
      txd0 = d;
      txv0 = 1'b1;
      @(posedge clock);
      #1 txv0 = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic push3(input logic [7:0] d);
    int waited = 0;
    while (rdy3 !== 1'b1 && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    vectors++;
    if (rdy3 !== 1'b1) begin
      miscompares++;
      $display("FAIL push3_ready got %b expected 1", rdy3);
    end else begin
      txd3 = d;
      txv3 = 1'b1;
      @(posedge clock);
      #1 txv3 = 1'b0;
    end
    @(negedge clock);
  endtask

  // Mode 0 controller: 4 clocks low, 4 high; optional cs release with the last falling edge
  task automatic m0_byte(input logic [7:0] mo, input int nbits, input bit end_cs,
                         output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      pico0 = mo[7-i];
      tick(4);
      mi[7-i] = poci0;
      sclk0 = 1'b1;
      tick(4);
      sclk0 = 1'b0;
      if (end_cs && i == nbits - 1) cs0 = 1'b1;
    end
  endtask

  // Mode 3 controller: falling edge drives, rising edge samples
  task automatic m3_byte(input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sclk3 = 1'b0;
      pico3 = mo[7-i];
      tick(4);
      mi[7-i] = poci3;
      sclk3 = 1'b1;
      tick(4);
    end
  endtask

  task automatic test_reset;
    tick(3);
    vectors++; if (poci0 !== 1'b0) begin miscompares++; $display("FAIL rst_poci got %b expected 0", poci0); end
    vectors++; if (oe0 !== 1'b0) begin miscompares++; $display("FAIL rst_poci_oe got %b expected 0", oe0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b expected 0", busy0); end
    vectors++; if (rxd0 !== 8'h00) begin miscompares++; $display("FAIL rst_rx_data got %h expected 00", rxd0); end
    vectors++; if (rxv0 !== 1'b0) begin miscompares++; $display("FAIL rst_rx_valid got %b expected 0", rxv0); end
    vectors++; if (und0 !== 1'b0) begin miscompares++; $display("FAIL rst_underrun got %b expected 0", und0); end
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL rst_tx_ready got %b expected 1", rdy0); end
    vectors++; if (poci3 !== 1'b0 || busy3 !== 1'b0) begin miscompares++; $display("FAIL rst_m3_idle got poci=%b busy=%b expected 0/0", poci3, busy3); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_mode0_basic;
    logic [7:0] mi;
    int rb = rx_cnt0;
    int ub = und_cnt0;
    push0(8'hA5);
    vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL m0_buf_full got %b expected 0", rdy0); end
    cs0 = 1'b0;
    m0_byte(8'h3C, 8, 1'b1, mi);
    tick(4);
    vectors++; if (mi !== 8'hA5) begin miscompares++; $display("FAIL m0_miso got %h expected a5", mi); end
    vectors++; if (rxd0 !== 8'h3C) begin miscompares++; $display("FAIL m0_rx_data got %h expected 3c", rxd0); end
    vectors++; if (rx_cnt0 - rb !== 1) begin miscompares++; $display("FAIL m0_rx_pulses got %0d expected 1", rx_cnt0 - rb); end
    vectors++; if (und_cnt0 - ub !== 0) begin miscompares++; $display("FAIL m0_underrun got %0d expected 0", und_cnt0 - ub); end
    vectors++; if (busy0 !== 1'b0 || oe0 !== 1'b0) begin miscompares++; $display("FAIL m0_end_idle got busy=%b oe=%b expected 0/0", busy0, oe0); end
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL m0_ready_after got %b expected 1", rdy0); end
  endtask

  task automatic test_mode3_burst;
    logic [7:0] mi0, mi1, mi2;
    int rb = rx_cnt3;
    int ub = und_cnt3;
    push3(8'h01);
    cs3 = 1'b0;
    fork
      begin
        push3(8'h02);
        push3(8'h03);
      end
      begin
        tick(4);
        m3_byte(8'hF0, mi0);
        m3_byte(8'h0F, mi1);
        m3_byte(8'hFF, mi2);
        tick(2);
        cs3 = 1'b1;
        tick(4);
      end
    join
    vectors++; if (mi0 !== 8'h01) begin miscompares++; $display("FAIL m3_miso0 got %h expected 01", mi0); end
    vectors++; if (mi1 !== 8'h02) begin miscompares++; $display("FAIL m3_miso1 got %h expected 02", mi1); end
    vectors++; if (mi2 !== 8'h03) begin miscompares++; $display("FAIL m3_miso2 got %h expected 03", mi2); end
    vectors++; if (rx_cnt3 - rb !== 3) begin miscompares++; $display("FAIL m3_rx_pulses got %0d expected 3", rx_cnt3 - rb); end
    vectors++; if (rx_log3[rb % 16] !== 8'hF0) begin miscompares++; $display("FAIL m3_rx0 got %h expected f0", rx_log3[rb % 16]); end
    vectors++; if (rx_log3[(rb + 1) % 16] !== 8'h0F) begin miscompares++; $display("FAIL m3_rx1 got %h expected 0f", rx_log3[(rb + 1) % 16]); end
    vectors++; if (rx_log3[(rb + 2) % 16] !== 8'hFF) begin miscompares++; $display("FAIL m3_rx2 got %h expected ff", rx_log3[(rb + 2) % 16]); end
    vectors++; if (und_cnt3 - ub !== 1) begin miscompares++; $display("FAIL m3_tail_underrun got %0d expected 1", und_cnt3 - ub); end
    vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL m3_end_busy got %b expected 0", busy3); end
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    int ub = und_cnt0;
    cs0 = 1'b0;
    m0_byte(8'h81, 8, 1'b1, mi);
    tick(4);
    vectors++; if (mi !== 8'h5A) begin miscompares++; $display("FAIL ur_miso got %h expected 5a", mi); end
    vectors++; if (und_cnt0 - ub !== 1) begin miscompares++; $display("FAIL ur_pulses got %0d expected 1", und_cnt0 - ub); end
    vectors++; if (rxd0 !== 8'h81) begin miscompares++; $display("FAIL ur_rx_data got %h expected 81", rxd0); end
    // bypass: tx_valid presented only on the load cycle
    ub = und_cnt0;
    cs0 = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    txd0 = 8'h77;
    txv0 = 1'b1;
    @(posedge clock);
    #1;
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL byp_ready got %b expected 1", rdy0); end
    vectors++; if (busy0 !== 1'b1 || oe0 !== 1'b1) begin miscompares++; $display("FAIL byp_busy got busy=%b oe=%b expected 1/1", busy0, oe0); end
    txv0 = 1'b0;
    m0_byte(8'hC6, 8, 1'b1, mi);
    tick(4);
    vectors++; if (mi !== 8'h77) begin miscompares++; $display("FAIL byp_miso got %h expected 77", mi); end
    vectors++; if (und_cnt0 - ub !== 0) begin miscompares++; $display("FAIL byp_underrun got %0d expected 0", und_cnt0 - ub); end
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL byp_ready_after got %b expected 1", rdy0); end
  endtask

  task automatic test_cs_abort;
    logic [7:0] mi;
    int rb = rx_cnt0;
    cs0 = 1'b0;
    tick(3);
    push0(8'hC3);
    m0_byte(8'hA0, 5, 1'b0, mi);
    tick(4);
    cs0 = 1'b1;
    tick(2);
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL ab_busy_2clk got %b expected 1", busy0); end
    tick(1);
    vectors++; if (busy0 !== 1'b0 || oe0 !== 1'b0) begin miscompares++; $display("FAIL ab_idle_3clk got busy=%b oe=%b expected 0/0", busy0, oe0); end
    vectors++; if (poci0 !== 1'b0) begin miscompares++; $display("FAIL ab_poci got %b expected 0", poci0); end
    vectors++; if (rx_cnt0 - rb !== 0) begin miscompares++; $display("FAIL ab_rx_pulses got %0d expected 0", rx_cnt0 - rb); end
    vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL ab_buf_kept got %b expected 0", rdy0); end
    tick(4);
    cs0 = 1'b0;
    m0_byte(8'h00, 8, 1'b1, mi);
    tick(4);
    vectors++; if (mi !== 8'hC3) begin miscompares++; $display("FAIL ab_next_miso got %h expected c3", mi); end
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL ab_ready_after got %b expected 1", rdy0); end
  endtask

  task automatic test_buf_full_hold;
    logic [7:0] mi;
    int ub = und_cnt0;
    push0(8'h11);
    txd0 = 8'h22;
    txv0 = 1'b1;
    tick(3);
    vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL hold_ready got %b expected 0", rdy0); end
    cs0 = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL hold_pre_load got %b expected 0", rdy0); end
    @(posedge clock);
    #1;
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL hold_post_load got %b expected 1", rdy0); end
    txv0 = 1'b0;
    m0_byte(8'h69, 8, 1'b1, mi);
    tick(4);
    vectors++; if (mi !== 8'h11) begin miscompares++; $display("FAIL hold_miso got %h expected 11", mi); end
    vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL hold_no_write got %b expected 1", rdy0); end
    vectors++; if (und_cnt0 - ub !== 0) begin miscompares++; $display("FAIL hold_underrun got %0d expected 0", und_cnt0 - ub); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi;
    int rb;
    cs0 = 1'b0;
    tick(3);
    push0(8'h4B);
    m0_byte(8'hFF, 4, 1'b0, mi);
    tick(3);
    vectors++; if (poci0 !== 1'b1) begin miscompares++; $display("FAIL rm_poci_pre got %b expected 1", poci0); end
    vectors++; if (rxd0 !== 8'h69) begin miscompares++; $display("FAIL rm_rx_pre got %h expected 69", rxd0); end
    reset = 1'b1;
    cs0 = 1'b1;
    @(posedge clock);
    #1;
    vectors++; if (poci0 !== 1'b0 || oe0 !== 1'b0 || busy0 !== 1'b0) begin miscompares++; $display("FAIL rm_bus got poci=%b oe=%b busy=%b expected 0/0/0", poci0, oe0, busy0); end
    vectors++; if (rxd0 !== 8'h00 || rxv0 !== 1'b0) begin miscompares++; $display("FAIL rm_rx got data=%h valid=%b expected 00/0", rxd0, rxv0); end
    vectors++; if (und0 !== 1'b0 || rdy0 !== 1'b1) begin miscompares++; $display("FAIL rm_tx got und=%b ready=%b expected 0/1", und0, rdy0); end
    @(negedge clock);
    reset = 1'b0;
    tick(4);
    rb = rx_cnt0;
    push0(8'h96);
    cs0 = 1'b0;
    m0_byte(8'h96, 8, 1'b1, mi);
    tick(4);
    vectors++; if (mi !== 8'h96) begin miscompares++; $display("FAIL rm_miso got %h expected 96", mi); end
    vectors++; if (rxd0 !== 8'h96) begin miscompares++; $display("FAIL rm_rx_data got %h expected 96", rxd0); end
    vectors++; if (rx_cnt0 - rb !== 1) begin miscompares++; $display("FAIL rm_rx_pulses got %0d expected 1", rx_cnt0 - rb); end
  endtask

  initial begin
    test_reset;
    test_mode0_basic;
    test_mode3_burst;
    test_underrun;
    test_cs_abort;
    test_buf_full_hold;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
